// File: rtl/load_store_unit_if.sv
// Word-wide data RAM request bus between the load/store unit (master) and the RAM (slave).
interface load_store_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    mem_req;
  logic                    mem_we;
  logic [DATA_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH/8-1:0] mem_wstrb;
  logic                    mem_ready;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: issues one RAM request per load/store, stalls the pipeline
// until it completes, and extends load data; flags misalignment and RAM timeouts.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] WriteData,
  load_store_unit_if.master     mem,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  Stall,
  output logic                  Misaligned,
  output logic                  BusError
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic               req_reg;
  logic               we_reg;
  logic [31:0]        addr_reg;
  logic [31:0]        wdata_reg;
  logic [LANES-1:0]   wstrb_reg;
  logic [2:0]         funct3_reg;
  logic [1:0]         off_reg;
  logic [31:0]        read_data_reg;
  logic               bus_error_reg;

  logic               cmd_seen;
  logic               bad_align;
  logic               timeout_hit;
  logic [31:0]        lane_wdata;
  logic [LANES-1:0]   lane_wstrb;
  logic [31:0]        rdata_shifted;
  logic [7:0]         sel_byte;
  logic [15:0]        sel_half;
  logic [31:0]        load_ext;

  assign cmd_seen    = MemRead | MemWrite;
  assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT - 1));

  always_comb begin
    case (funct3[1:0])
      2'b00:   bad_align = 1'b0;
      2'b01:   bad_align = ALUResult[0];
      2'b10:   bad_align = (ALUResult[1:0] != 2'b00);
      default: bad_align = 1'b1;
    endcase
  end

  // Store data is replicated across lanes so the strobes alone pick the target bytes.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam logic [1:0] LANE_IDX = 2'(gi);
    assign lane_wdata[gi*8 +: 8] = (funct3[1:0] == 2'b10) ? WriteData[gi*8 +: 8] :
                                   (funct3[1:0] == 2'b01) ? WriteData[(gi%2)*8 +: 8] :
                                                            WriteData[7:0];
    assign lane_wstrb[gi] = (funct3[1:0] == 2'b10) ? 1'b1 :
                            (funct3[1:0] == 2'b01) ? (ALUResult[1] == LANE_IDX[1]) :
                                                     (ALUResult[1:0] == LANE_IDX);
  end

  assign rdata_shifted = mem.mem_rdata >> {off_reg, 3'b000};
  assign sel_byte      = rdata_shifted[7:0];
  assign sel_half      = off_reg[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];

  always_comb begin
    case (funct3_reg)
      3'b000:  load_ext = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_ext = {{16{sel_half[15]}}, sel_half};
      3'b100:  load_ext = {24'h0, sel_byte};
      3'b101:  load_ext = {16'h0, sel_half};
      default: load_ext = mem.mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    Stall      = 1'b0;
    Misaligned = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cmd_seen) begin
          if (bad_align) begin
            Misaligned = 1'b1;
          end else begin
            Stall      = 1'b1;
            state_next = ACCESS;
          end
        end
      end
      ACCESS: begin
        Stall = 1'b1;
        if (mem.mem_ready || timeout_hit) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg       <= '0;
      req_reg       <= 1'b0;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      funct3_reg    <= '0;
      off_reg       <= '0;
      read_data_reg <= '0;
      bus_error_reg <= 1'b0;
    end else begin
      bus_error_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cmd_seen && !bad_align) begin
            req_reg    <= 1'b1;
            we_reg     <= MemWrite;
            addr_reg   <= {ALUResult[31:2], 2'b00};
            wdata_reg  <= lane_wdata;
            wstrb_reg  <= MemWrite ? lane_wstrb : '0;
            funct3_reg <= funct3;
            off_reg    <= ALUResult[1:0];
            cnt_reg    <= '0;
          end
        end
        ACCESS: begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (mem.mem_ready || timeout_hit) begin
            req_reg       <= 1'b0;
            we_reg        <= 1'b0;
            wstrb_reg     <= '0;
            bus_error_reg <= !mem.mem_ready;
            // A timed-out load retires with zero rather than stale data.
            if (!we_reg) read_data_reg <= mem.mem_ready ? load_ext : 32'h0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem.mem_req   = req_reg;
  assign mem.mem_we    = we_reg;
  assign mem.mem_addr  = addr_reg;
  assign mem.mem_wdata = wdata_reg;
  assign mem.mem_wstrb = wstrb_reg;
  assign ReadData      = read_data_reg;
  assign BusError      = bus_error_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed-vector bench for load_store_unit with a behavioural RAM driving ready/rdata.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  funct3;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        Misaligned;
  logic        BusError;

  int checks = 0;
  int errors = 0;

  // Observations from the most recent run_access
  int          r_stall, r_req, r_done_cyc;
  logic        r_done, r_done_req, r_berr, r_we, r_after_req, r_after_berr;
  logic [31:0] r_addr, r_wdata, r_rd;
  logic [3:0]  r_wstrb;

  always #5 clk = ~clk;

  load_store_unit_if #(.DATA_WIDTH(32)) mem_bus ();

  load_store_unit #(.DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .funct3    (funct3),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .mem       (mem_bus),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .Misaligned(Misaligned),
    .BusError  (BusError)
  );

  // Issues one command from an IDLE cycle and plays the RAM; waits < 0 means never ready.
  // Commands stay asserted through DONE and are dropped after the following edge.
  task automatic run_access(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rword, input int waits);
    MemWrite  = wr;
    MemRead   = !wr;
    funct3    = f3;
    ALUResult = addr;
    WriteData = wd;
    mem_bus.mem_ready = 1'b0;
    r_stall = 0; r_req = 0; r_done = 1'b0; r_done_cyc = -1;
    r_addr = 'x; r_wdata = 'x; r_wstrb = 'x; r_we = 1'bx;
    r_done_req = 1'bx; r_berr = 1'bx; r_rd = 'x;
    for (int cyc = 0; cyc < 40 && !r_done; cyc++) begin
      #1;
      if (Stall) r_stall++;
      if (mem_bus.mem_req) begin
        r_req++;
        if (r_req == 1) begin
          r_addr  = mem_bus.mem_addr;
          r_wdata = mem_bus.mem_wdata;
          r_wstrb = mem_bus.mem_wstrb;
          r_we    = mem_bus.mem_we;
        end
        if (waits >= 0 && r_req > waits) begin
          mem_bus.mem_ready = 1'b1;
          mem_bus.mem_rdata = rword;
        end
      end
      if (cyc > 0 && !Stall) begin
        r_done     = 1'b1;
        r_done_cyc = cyc;
        r_done_req = mem_bus.mem_req;
        r_berr     = BusError;
        r_rd       = ReadData;
      end
      @(posedge clk);
      #1;
      mem_bus.mem_ready = 1'b0;
    end
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    #1;
    r_after_req  = mem_bus.mem_req;
    r_after_berr = BusError;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'b000;
    ALUResult = 32'h0; WriteData = 32'h0;
    mem_bus.mem_ready = 1'b0; mem_bus.mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_wstrb} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got req/we/wstrb=%b expected 000000",
                         {mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_wstrb});
    end
    checks++;
    if (mem_bus.mem_addr !== 32'h0 || mem_bus.mem_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_bus: got addr=%h wdata=%h expected 0/0",
                         mem_bus.mem_addr, mem_bus.mem_wdata);
    end
    checks++;
    if (ReadData !== 32'h0 || {Stall, Misaligned, BusError} !== 3'b000) begin
      errors++; $display("FAIL reset_out: got ReadData=%h flags=%b expected 0/000",
                         ReadData, {Stall, Misaligned, BusError});
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    $display("reset: ReadData=%h mem_req=%b", ReadData, mem_bus.mem_req);
  endtask

  task automatic test_sw();
    run_access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0);
    $display("SW 0x100: addr=%h wdata=%h wstrb=%b stall=%0d done_cyc=%0d",
             r_addr, r_wdata, r_wstrb, r_stall, r_done_cyc);
    checks++;
    if (r_addr !== 32'h100 || r_wdata !== 32'hDEADBEEF || r_wstrb !== 4'b1111 || r_we !== 1'b1) begin
      errors++; $display("FAIL sw_bus: got addr=%h wdata=%h wstrb=%b we=%b expected 00000100 deadbeef 1111 1",
                         r_addr, r_wdata, r_wstrb, r_we);
    end
    checks++;
    if (r_stall !== 2 || r_done_cyc !== 2 || r_req !== 1) begin
      errors++; $display("FAIL sw_timing: got stall=%0d done_cyc=%0d req=%0d expected 2 2 1",
                         r_stall, r_done_cyc, r_req);
    end
    checks++;
    if (r_done_req !== 1'b0 || r_after_req !== 1'b0 || r_berr !== 1'b0) begin
      errors++; $display("FAIL sw_retire: got done_req=%b after_req=%b berr=%b expected 0 0 0",
                         r_done_req, r_after_req, r_berr);
    end
  endtask

  task automatic test_sb_lb();
    run_access(1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0);
    $display("SB 0x103: wdata=%h wstrb=%b", r_wdata, r_wstrb);
    checks++;
    if (r_wdata !== 32'hA5A5A5A5 || r_wstrb !== 4'b1000 || r_addr !== 32'h100) begin
      errors++; $display("FAIL sb_bus: got addr=%h wdata=%h wstrb=%b expected 00000100 a5a5a5a5 1000",
                         r_addr, r_wdata, r_wstrb);
    end
    run_access(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 0);
    $display("SH 0x102: wdata=%h wstrb=%b", r_wdata, r_wstrb);
    checks++;
    if (r_wdata !== 32'hABCDABCD || r_wstrb !== 4'b1100) begin
      errors++; $display("FAIL sh_bus: got wdata=%h wstrb=%b expected abcdabcd 1100", r_wdata, r_wstrb);
    end
    run_access(1'b0, 3'b000, 32'h103, 32'h0, 32'hA5000000, 0);
    $display("LB 0x103: ReadData=%h we=%b", r_rd, r_we);
    checks++;
    if (r_rd !== 32'hFFFFFFA5 || r_we !== 1'b0 || r_wstrb !== 4'b0000) begin
      errors++; $display("FAIL lb_sext: got ReadData=%h we=%b wstrb=%b expected ffffffa5 0 0000",
                         r_rd, r_we, r_wstrb);
    end
    run_access(1'b0, 3'b100, 32'h103, 32'h0, 32'hA5000000, 0);
    $display("LBU 0x103: ReadData=%h", r_rd);
    checks++;
    if (r_rd !== 32'h000000A5) begin
      errors++; $display("FAIL lbu_zext: got ReadData=%h expected 000000a5", r_rd);
    end
  endtask

  task automatic test_lh_wait();
    run_access(1'b0, 3'b001, 32'h102, 32'h0, 32'h80011234, 3);
    $display("LH 0x102 3 waits: ReadData=%h stall=%0d", r_rd, r_stall);
    checks++;
    if (r_rd !== 32'hFFFF8001) begin
      errors++; $display("FAIL lh_sext: got ReadData=%h expected ffff8001", r_rd);
    end
    checks++;
    if (r_stall !== 5 || r_req !== 4 || r_done !== 1'b1) begin
      errors++; $display("FAIL lh_stall: got stall=%0d req=%0d done=%b expected 5 4 1",
                         r_stall, r_req, r_done);
    end
    run_access(1'b0, 3'b101, 32'h102, 32'h0, 32'h80011234, 0);
    $display("LHU 0x102: ReadData=%h", r_rd);
    checks++;
    if (r_rd !== 32'h00008001) begin
      errors++; $display("FAIL lhu_zext: got ReadData=%h expected 00008001", r_rd);
    end
  endtask

  task automatic test_misaligned();
    logic [2:0]  f3s   [3];
    logic [31:0] addrs [3];
    logic [31:0] held;
    f3s[0] = 3'b010; addrs[0] = 32'h101;
    f3s[1] = 3'b001; addrs[1] = 32'h103;
    f3s[2] = 3'b011; addrs[2] = 32'h100;
    held = ReadData;
    for (int i = 0; i < 3; i++) begin
      MemRead = 1'b1; funct3 = f3s[i]; ALUResult = addrs[i];
      #1;
      $display("misaligned f3=%b addr=%h: Misaligned=%b Stall=%b req=%b",
               f3s[i], addrs[i], Misaligned, Stall, mem_bus.mem_req);
      checks++;
      if ({Misaligned, Stall, mem_bus.mem_req} !== 3'b100) begin
        errors++; $display("FAIL misalign_flag[%0d]: got mis/stall/req=%b expected 100",
                           i, {Misaligned, Stall, mem_bus.mem_req});
      end
      @(posedge clk);
      #1;
      MemRead = 1'b0;
      #1;
      checks++;
      if (mem_bus.mem_req !== 1'b0 || Misaligned !== 1'b0 || ReadData !== held) begin
        errors++; $display("FAIL misalign_after[%0d]: got req=%b mis=%b ReadData=%h expected 0 0 %h",
                           i, mem_bus.mem_req, Misaligned, ReadData, held);
      end
    end
  endtask

  task automatic test_timeout();
    run_access(1'b0, 3'b010, 32'h200, 32'h0, 32'h0, -1);
    $display("LW 0x200 no ready: BusError=%b ReadData=%h req=%0d stall=%0d",
             r_berr, r_rd, r_req, r_stall);
    checks++;
    if (r_berr !== 1'b1 || r_rd !== 32'h0 || r_done !== 1'b1) begin
      errors++; $display("FAIL timeout_err: got berr=%b ReadData=%h done=%b expected 1 00000000 1",
                         r_berr, r_rd, r_done);
    end
    checks++;
    if (r_req !== 16 || r_stall !== 17 || r_after_berr !== 1'b0) begin
      errors++; $display("FAIL timeout_len: got req=%0d stall=%0d berr_after=%b expected 16 17 0",
                         r_req, r_stall, r_after_berr);
    end
  endtask

  task automatic test_reset_in_access();
    run_access(1'b0, 3'b010, 32'h104, 32'h0, 32'h12345678, 0);
    checks++;
    if (r_rd !== 32'h12345678) begin
      errors++; $display("FAIL lw_word: got ReadData=%h expected 12345678", r_rd);
    end
    MemRead = 1'b1; funct3 = 3'b010; ALUResult = 32'h108; mem_bus.mem_ready = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (mem_bus.mem_req !== 1'b1) begin
      errors++; $display("FAIL rst_access_req: got req=%b expected 1", mem_bus.mem_req);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    MemRead = 1'b0;
    #1;
    $display("reset in ACCESS: req=%b ReadData=%h Stall=%b", mem_bus.mem_req, ReadData, Stall);
    checks++;
    if (mem_bus.mem_req !== 1'b0 || ReadData !== 32'h0 || Stall !== 1'b0) begin
      errors++; $display("FAIL rst_access_clear: got req=%b ReadData=%h Stall=%b expected 0 00000000 0",
                         mem_bus.mem_req, ReadData, Stall);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_access(1'b1, 3'b010, 32'h10C, 32'hCAFEF00D, 32'h0, 1);
    $display("SW 0x10C after reset: addr=%h wdata=%h stall=%0d", r_addr, r_wdata, r_stall);
    checks++;
    if (r_addr !== 32'h10C || r_wdata !== 32'hCAFEF00D || r_wstrb !== 4'b1111 ||
        r_stall !== 3 || r_done !== 1'b1) begin
      errors++; $display("FAIL rst_recover: got addr=%h wdata=%h wstrb=%b stall=%0d done=%b expected 0000010c cafef00d 1111 3 1",
                         r_addr, r_wdata, r_wstrb, r_stall, r_done);
    end
  endtask

  initial begin
    test_reset();
    test_sw();
    test_sb_lb();
    test_lh_wait();
    test_misaligned();
    test_timeout();
    test_reset_in_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage directly downstream of the execute stage. Takes the execute stage's ALU result as the byte address and its rs2 operand as store data. Drives a word-wide data RAM through a req/ready handshake, with byte strobes for SB/SH/SW and sign or zero extension for LB/LH/LW/LBU/LHU. Asserts Stall to freeze PC and register writeback until the access completes; flags misaligned or illegal-width accesses and memory timeouts.

## Interface
- DATA_WIDTH, 32, data and address width (fixed 32; byte lanes = 4)
- TIMEOUT, 16, maximum ACCESS cycles waiting for mem_ready before bus error

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- MemRead  in  1  current instruction is a load
- MemWrite  in  1  current instruction is a store; wins over MemRead if both set
- funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; funct3[1:0]==11 illegal
- ALUResult  in  32  byte address
- WriteData  in  32  store data (rs2)
- mem_req  out  1  request valid to RAM
- mem_we  out  1  1 = write
- mem_addr  out  32  word address, {ALUResult[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte write enables
- mem_ready  in  1  RAM accepts/completes request this cycle
- mem_rdata  in  32  read word, valid when mem_ready & ~mem_we
- ReadData  out  32  extended load result
- Stall  out  1  hold PC/pipeline this cycle
- Misaligned  out  1  one-cycle flag: misaligned or illegal width
- BusError  out  1  one-cycle flag: TIMEOUT exceeded

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE, no MemRead/MemWrite: outputs idle, Stall=0.
- IDLE, command with bad alignment → stay IDLE; no request; Misaligned=1 combinationally; Stall=0; ReadData unchanged.
  - Bad alignment: H/HU with addr[0]=1, W with addr[1:0]≠0, or funct3[1:0]=11.
- IDLE, valid command → Stall=1; register mem_addr, mem_we, mem_wdata, mem_wstrb, funct3 and addr[1:0]; clear timeout counter; go ACCESS.
- ACCESS: mem_req=1, Stall=1, request fields held stable. Counter increments each cycle.
  - mem_ready=1 → capture (loads: extend mem_rdata into ReadData), go DONE.
  - Counter reaches TIMEOUT-1 without ready → go DONE with BusError pulsed in DONE; ReadData forced 0 for loads.
- DONE: Stall=0, mem_req=0; instruction retires this cycle; always go IDLE next cycle, ignoring still-asserted MemRead/MemWrite. No command is re-issued.
- Store lanes:
  - SB: wstrb = 0001<<addr[1:0], wdata = {4{WriteData[7:0]}}
  - SH: wstrb = addr[1] ? 1100 : 0011, wdata = {2{WriteData[15:0]}}
  - SW: wstrb = 1111, wdata = WriteData
- Load extraction: select byte by addr[1:0] or half by addr[1]; B/H sign-extend, BU/HU zero-extend, W unchanged.
- ReadData holds the last load result; stores, misaligned accesses and idle cycles do not change it.

## Timing
- Reset (rst_n=0 at clk edge): state IDLE, counter 0, mem_req/mem_we/mem_wstrb 0, mem_addr/mem_wdata 0, ReadData 0, Misaligned/BusError 0.
- Reset during ACCESS: mem_req drops on the edge after reset is sampled; RAM must tolerate the abandoned request.
- mem_req is registered. The first request cycle is the cycle after the command is seen.
- Zero-wait RAM (ready in first ACCESS cycle): Stall high for 2 cycles; result valid in the 3rd (DONE) cycle. Each wait state adds 1 cycle.
- Stall is combinational: (IDLE & valid command) | ACCESS.
- ReadData is registered and valid from DONE onward.
- Misaligned is combinational in IDLE. BusError is registered and asserted only in DONE.

## Test plan
- SW 0xDEADBEEF to 0x100, RAM ready immediately → mem_addr=0x100, wstrb=1111, wdata=0xDEADBEEF; Stall 2 cycles; DONE on cycle 3.
- SB 0x000000A5 to 0x103, then LB from 0x103 with rdata=0xA5000000 → wstrb=1000, wdata=0xA5A5A5A5; ReadData=0xFFFFFFA5; LBU gives 0x000000A5.
- LH from 0x102 with rdata=0x8001_1234, ready after 3 wait cycles → Stall 5 cycles; ReadData=0xFFFF8001; LHU=0x00008001.
- LW at 0x101; LH at 0x103; funct3=011 → Misaligned=1 one cycle each; mem_req never asserted; Stall=0; ReadData unchanged.
- mem_ready held low → BusError=1 after TIMEOUT ACCESS cycles; ReadData=0; Stall released in DONE.
- rst_n low in second ACCESS cycle → next edge: mem_req=0, state IDLE, ReadData=0; a new SW then completes normally.
